// File: rtl/lockin_ref_dds.sv
// lockin_ref_dds: quadrature sine/cosine reference generator for the lock-in DAC path.
//
// A 32-bit phase accumulator advances once per sample period (SAMPLE_DIV clocks).
// Its top byte addresses a quarter-wave sine ROM. Two 12-bit offset-binary codes
// (sine on V_A, cosine on V_B) are produced three clocks after each tick.
//
// Parameters
//   SAMPLE_DIV  clocks per output sample (>= 4)
//   FTW_RESET   tuning word loaded into active and pending registers at reset
//
// Ports
//   CLK_50M      in   system clock
//   RST_N        in   asynchronous active-low reset
//   en           in   run enable; low holds the sample counter at 0
//   ftw_in       in   new frequency tuning word
//   ftw_load     in   strobe capturing ftw_in into the pending register
//   phase_clr    in   strobe requesting an accumulator clear at the next tick
//   ftw_pending  out  a loaded word is waiting for the next tick
//   V_A          out  sine code (DAC channel A)
//   V_B          out  cosine code (DAC channel B)
//   synchro      out  one-cycle pulse marking a new V_A/V_B pair
module lockin_ref_dds #(
    parameter int          SAMPLE_DIV = 528,
    parameter logic [31:0] FTW_RESET  = 32'h0
) (
    input  logic        CLK_50M,
    input  logic        RST_N,
    input  logic        en,
    input  logic [31:0] ftw_in,
    input  logic        ftw_load,
    input  logic        phase_clr,
    output logic        ftw_pending,
    output logic [11:0] V_A,
    output logic [11:0] V_B,
    output logic        synchro
);
    localparam int CW = $clog2(SAMPLE_DIV);

    // mag[i] = round(2047 * sin(pi * (i + 0.5) / 128))
    localparam logic [10:0] MAG [64] = '{
        11'd25,   11'd75,   11'd126,  11'd176,  11'd226,  11'd275,  11'd325,  11'd375,
        11'd424,  11'd473,  11'd522,  11'd570,  11'd618,  11'd666,  11'd713,  11'd760,
        11'd807,  11'd852,  11'd898,  11'd943,  11'd987,  11'd1031, 11'd1074, 11'd1116,
        11'd1158, 11'd1199, 11'd1239, 11'd1279, 11'd1318, 11'd1356, 11'd1393, 11'd1430,
        11'd1465, 11'd1500, 11'd1533, 11'd1566, 11'd1598, 11'd1629, 11'd1659, 11'd1688,
        11'd1716, 11'd1743, 11'd1769, 11'd1793, 11'd1817, 11'd1840, 11'd1861, 11'd1881,
        11'd1901, 11'd1919, 11'd1936, 11'd1951, 11'd1966, 11'd1979, 11'd1992, 11'd2003,
        11'd2012, 11'd2021, 11'd2028, 11'd2035, 11'd2039, 11'd2043, 11'd2046, 11'd2047
    };

    // Odd quadrants read the ROM mirrored (63 - i == ~i on 6 bits).
    function automatic logic [10:0] quad_mag(input logic [7:0] x);
        return MAG[x[6] ? ~x[5:0] : x[5:0]];
    endfunction

    logic [CW-1:0] cnt;
    logic          tick;
    logic          clr_req;
    logic          do_clr;
    logic [31:0]   acc;
    logic [31:0]   ftw_active;
    logic [31:0]   ftw_pending_reg;
    logic [7:0]    p_now;
    logic [7:0]    p0;
    logic [7:0]    pc0;
    logic          v0;
    logic          v1;
    logic [10:0]   mag_a;
    logic [10:0]   mag_b;
    logic          neg_a;
    logic          neg_b;

    assign tick   = en && (cnt == CW'(SAMPLE_DIV - 1));
    // A clear strobe coinciding with a tick is honoured by that same tick.
    assign do_clr = clr_req || phase_clr;
    assign p_now  = do_clr ? 8'd0 : acc[31:24];

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            cnt             <= '0;
            acc             <= '0;
            ftw_active      <= FTW_RESET;
            ftw_pending_reg <= FTW_RESET;
            ftw_pending     <= 1'b0;
            clr_req         <= 1'b0;
        end else begin
            cnt         <= (!en || tick) ? '0 : cnt + CW'(1);
            // A load in a tick cycle wins: the word stays pending for the next tick.
            ftw_pending <= ftw_load || (ftw_pending && !tick);
            clr_req     <= do_clr && !tick;
            if (ftw_load)
                ftw_pending_reg <= ftw_in;
            if (tick) begin
                acc <= (do_clr ? 32'd0 : acc) + ftw_active;
                if (ftw_pending)
                    ftw_active <= ftw_pending_reg;
            end
        end
    end

    // Three-stage sample pipeline: phase capture, ROM lookup, code formation.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            v0      <= 1'b0;
            v1      <= 1'b0;
            synchro <= 1'b0;
            p0      <= '0;
            pc0     <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            neg_a   <= 1'b0;
            neg_b   <= 1'b0;
            V_A     <= 12'd2048;
            V_B     <= 12'd2048;
        end else begin
            v0      <= tick;
            v1      <= v0;
            synchro <= v1;
            if (tick) begin
                p0  <= p_now;
                pc0 <= p_now + 8'd64;
            end
            if (v0) begin
                mag_a <= quad_mag(p0);
                mag_b <= quad_mag(pc0);
                neg_a <= p0[7];
                neg_b <= pc0[7];
            end
            if (v1) begin
                V_A <= neg_a ? 12'd2048 - {1'b0, mag_a} : 12'd2048 + {1'b0, mag_a};
                V_B <= neg_b ? 12'd2048 - {1'b0, mag_b} : 12'd2048 + {1'b0, mag_b};
            end
        end
    end
endmodule

// File: tb/tb_lockin_ref_dds.sv
// tb_lockin_ref_dds: directed self-checking bench for lockin_ref_dds.
module tb_lockin_ref_dds;
    localparam int DIV = 8;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        en        = 1'b1;
    logic [31:0] ftw_in    = 32'h0;
    logic        ftw_load  = 1'b0;
    logic        phase_clr = 1'b0;
    logic        ftw_pending;
    logic        synchro;
    logic [11:0] v_a;
    logic [11:0] v_b;

    int errors = 0;
    int checks = 0;
    int n;
    int cnt;
    int bad_n;
    int bad_sym;
    int bad_quad;
    int va [256];
    int vb [256];
    int q_a [4] = '{2073, 4095, 2023, 1};
    int q_b [4] = '{4095, 2023, 1, 2073};

    always #10 clk = ~clk;

    lockin_ref_dds #(.SAMPLE_DIV(DIV), .FTW_RESET(32'h4000_0000)) dut (
        .CLK_50M    (clk),
        .RST_N      (rst_n),
        .en         (en),
        .ftw_in     (ftw_in),
        .ftw_load   (ftw_load),
        .phase_clr  (phase_clr),
        .ftw_pending(ftw_pending),
        .V_A        (v_a),
        .V_B        (v_b),
        .synchro    (synchro)
    );

    function automatic int mag_model(input int i);
        return int'($floor(2047.0 * $sin(3.14159265358979 * (i + 0.5) / 128.0) + 0.5));
    endfunction

    function automatic int code_model(input int x);
        int q;
        int i;
        int m;
        q = (x >> 6) & 3;
        i = x & 63;
        m = mag_model((q % 2 == 1) ? 63 - i : i);
        return (q >= 2) ? 2048 - m : 2048 + m;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_sync(output int k);
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!synchro && k < 64);
    endtask

    task automatic pulse_load(input logic [31:0] w);
        ftw_in   = w;
        ftw_load = 1'b1;
        step(1);
        ftw_load = 1'b0;
    endtask

    task automatic pulse_clr();
        phase_clr = 1'b1;
        step(1);
        phase_clr = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step(3);
        check("rst_va", v_a, 2048);
        check("rst_vb", v_b, 2048);
        check("rst_sync", synchro, 0);
        check("rst_pend", ftw_pending, 0);

        rst_n = 1'b1;
        wait_sync(n);
        check("first_lat", n, DIV + 2);
        check("first_va", v_a, 2073);
        check("first_vb", v_b, 4095);
        step(1);
        check("sync_width", synchro, 0);
        check("hold_va", v_a, 2073);

        for (int k = 1; k < 4; k++) begin
            wait_sync(n);
            check($sformatf("quad_period%0d", k), n, k == 1 ? DIV - 1 : DIV);
            check($sformatf("quad_va%0d", k), v_a, q_a[k]);
            check($sformatf("quad_vb%0d", k), v_b, q_b[k]);
        end

        step(5);
        ftw_in   = 32'h0100_0000;
        ftw_load = 1'b1;
        step(1);
        ftw_load = 1'b0;
        check("coll_pend", ftw_pending, 1);
        wait_sync(n);
        check("coll_va_p00", v_a, 2073);
        check("coll_pend_kept", ftw_pending, 1);
        wait_sync(n);
        check("coll_va_p40", v_a, 4095);
        check("coll_pend_drop", ftw_pending, 0);
        wait_sync(n);
        check("coll_va_p80", v_a, 2023);
        wait_sync(n);
        check("coll_va_p81", v_a, 1973);
        check("coll_vb_p81", v_b, 2);
        wait_sync(n);
        check("coll_va_p82", v_a, 1922);

        pulse_load(32'h1234_5678);
        wait_sync(n);
        check("step_va_p83", v_a, 1872);
        wait_sync(n);
        check("step_va_p84", v_a, 1822);
        pulse_clr();
        wait_sync(n);
        check("clr_va", v_a, 2073);
        check("clr_vb", v_b, 4095);
        wait_sync(n);
        check("clr_next_va", v_a, 2946);
        check("clr_next_vb", v_b, 3888);

        step(6);
        en = 1'b0;
        wait_sync(n);
        check("en_drop_lat", n, 2);
        check("en_drop_va", v_a, 3646);
        check("en_drop_vb", v_b, 3327);
        pulse_load(32'h0100_0000);
        pulse_clr();
        cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            cnt += int'(synchro);
        end
        check("idle_syncs", cnt, 0);
        check("idle_hold_va", v_a, 3646);
        check("idle_pend", ftw_pending, 1);
        en = 1'b1;
        wait_sync(n);
        check("reen_lat", n, DIV + 2);
        check("reen_clr_va", v_a, 2073);
        check("reen_pend", ftw_pending, 0);

        step(6);
        rst_n = 1'b0;
        #1;
        check("midrst_va", v_a, 2048);
        check("midrst_vb", v_b, 2048);
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            cnt += int'(synchro);
        end
        check("midrst_syncs", cnt, 0);

        rst_n = 1'b1;
        wait_sync(n);
        check("rerst_lat", n, DIV + 2);
        check("rerst_va", v_a, 2073);
        pulse_load(32'h0100_0000);
        wait_sync(n);
        check("sweep_pre_va", v_a, 4095);
        pulse_clr();
        bad_n = 0;
        for (int k = 0; k < 256; k++) begin
            wait_sync(n);
            if (k > 0 && n != DIV)
                bad_n++;
            va[k] = int'(v_a);
            vb[k] = int'(v_b);
        end
        check("sweep_periods", bad_n, 0);
        for (int p = 0; p < 256; p++)
            check($sformatf("sweep_va_p%0d", p), va[p], code_model(p));
        bad_sym  = 0;
        bad_quad = 0;
        for (int p = 0; p < 256; p++) begin
            if (p < 128 && va[p] + va[p + 128] != 4096)
                bad_sym++;
            if (vb[p] != va[(p + 64) % 256])
                bad_quad++;
        end
        check("sweep_symmetry", bad_sym, 0);
        check("sweep_quadrature", bad_quad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
